// File: rtl/serial_instr_rx.sv
// serial_instr_rx: four-phase serial instruction receiver with frame timeout and FWFT FIFO.
// Define SERIAL_INSTR_RX_PARITY_CHECK_EN to append a trailing even-parity bit to each frame.
module serial_instr_rx #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_bit,
  input  logic                     confirm_bit,
  input  logic                     clear,
  output logic                     data_ready,
  output logic [WIDTH-1:0]         instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     parity_err
);
`ifdef SERIAL_INSTR_RX_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW  = $clog2(FRAME);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = AW + 1;
  typedef enum logic {WAIT_LOW, READY} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAME-2:0]  shift_q, shift_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [NW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  instr_q, instr_d, payload;
  logic              overflow_q, overflow_d, parity_err_q, parity_err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [FRAME-1:0]  frame;
  logic              cap, abort, done, tmo_fire, par_ok, push_req, push, pop;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= WAIT_LOW;
    else state_q <= state_d;
  // Both states leave on confirm_bit: low arms READY, high (in READY) is a capture or abort.
  always_comb state_d = confirm_bit ? WAIT_LOW : READY;
  always_comb data_ready = state_q == READY;
  always_comb begin
    cap      = state_q == READY && confirm_bit && !clear;
    abort    = state_q == READY && confirm_bit && clear;
    done     = cap && cnt_q == CW'(FRAME - 1);
    frame    = {shift_q, data_bit};
    tmo_fire = cnt_q != '0 && !cap && tmo_q == TW'(TIMEOUT - 1);
`ifdef SERIAL_INSTR_RX_PARITY_CHECK_EN
    payload  = frame[FRAME-1:1];
    par_ok   = ~^frame;
`else
    payload  = frame;
    par_ok   = 1'b1;
`endif
    cnt_d    = (abort || tmo_fire || done) ? '0 : cap ? cnt_q + CW'(1) : cnt_q;
    shift_d  = (abort || tmo_fire || done) ? '0 : cap ? frame[FRAME-2:0] : shift_q;
    tmo_d    = (cap || abort || tmo_fire || cnt_q == '0) ? '0 : tmo_q + TW'(1);
    pop      = count_q != '0 && instr_ready;
    push_req = done && par_ok;
    push     = push_req && (count_q != NW'(DEPTH) || pop);
    count_d  = count_q + NW'(push) - NW'(pop);
    rd_nx    = rd_q + AW'(1);
    rd_d     = pop ? rd_nx : rd_q;
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    // The head register follows whatever entry will sit at rd after this edge; it holds when emptied.
    instr_d  = (push && (count_q == '0 || (pop && count_q == NW'(1)))) ? payload :
               (pop && count_q > NW'(1)) ? mem_q[rd_nx] : instr_q;
    overflow_d   = abort ? 1'b0 : (push_req && !push) ? 1'b1 : overflow_q;
    parity_err_d = done && !par_ok;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      instr_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      instr_q      <= instr_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= payload;
  always_comb begin
    instr       = instr_q;
    instr_valid = count_q != '0;
    fifo_count  = count_q;
    overflow    = overflow_q;
    parity_err  = parity_err_q;
  end
endmodule

// File: tb/tb_serial_instr_rx.sv
// tb_serial_instr_rx: directed bench for serial_instr_rx (WIDTH=10, DEPTH=4, TIMEOUT=1000).
`timescale 1ns/1ps
module tb_serial_instr_rx;
`ifdef SERIAL_INSTR_RX_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 0, reset = 0, data_bit = 0, confirm_bit = 0, clear = 0, instr_ready = 0;
  logic data_ready, instr_valid, overflow, parity_err;
  logic [9:0] instr;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_err = 0;
  serial_instr_rx #(.WIDTH(10), .DEPTH(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .data_bit(data_bit), .confirm_bit(confirm_bit), .clear(clear),
    .data_ready(data_ready), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fifo_count(fifo_count), .overflow(overflow), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b, input logic c, input logic p);
    for (int k = 0; k < 50 && !data_ready; k++) @(negedge clk);
    if (!data_ready) chk("rdy_wait", 32'(data_ready), 1);
    data_bit = b; clear = c; confirm_bit = 1; instr_ready = p;
    @(negedge clk);
    confirm_bit = 0; clear = 0; instr_ready = 0;
  endtask
  task automatic send_frame(input logic [9:0] w, input logic p);
    for (int i = 9; i >= 0; i--) send_bit(w[i], 1'b0, p && !PAR && i == 0);
    if (PAR) send_bit(^w, 1'b0, p);
  endtask
  task automatic pop_one();
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(data_ready), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_perr", 32'(parity_err), 0);
    reset = 1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(data_ready), 1);
    send_frame(10'h2CE, 0);
    chk("f1_instr", 32'(instr), 32'h2CE);
    chk("f1_valid", 32'(instr_valid), 1);
    chk("f1_count", 32'(fifo_count), 1);
    chk("f1_perr", 32'(parity_err), 0);
    pop_one();
    chk("pop_valid", 32'(instr_valid), 0);
    chk("pop_count", 32'(fifo_count), 0);
    chk("pop_hold", 32'(instr), 32'h2CE);
    for (int i = 1; i <= 5; i++) send_frame(10'(i), 0);
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_set", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_head%0d", i), 32'(instr), i);
      pop_one();
    end
    chk("ovf_drained", 32'(instr_valid), 0);
    send_bit(0, 1, 0);
    chk("clr_ovf", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) send_frame(10'(i), 0);
    send_frame(10'h005, 1);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_count", 32'(fifo_count), 4);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("pp_head%0d", i), 32'(instr), i);
      pop_one();
    end
    chk("pp_drained", 32'(fifo_count), 0);
    repeat (4) send_bit(1, 0, 0);
    send_bit(0, 1, 0);
    send_frame(10'h3FF, 0);
    chk("abort_instr", 32'(instr), 32'h3FF);
    chk("abort_count", 32'(fifo_count), 1);
    chk("abort_ovf", 32'(overflow), 0);
    pop_one();
    repeat (3) send_bit(1, 0, 0);
    repeat (1010) @(negedge clk);
    send_frame(10'h155, 0);
    chk("tmo_instr", 32'(instr), 32'h155);
    chk("tmo_count", 32'(fifo_count), 1);
    pop_one();
`ifdef SERIAL_INSTR_RX_PARITY_CHECK_EN
    for (int i = 9; i >= 0; i--) send_bit(10'h2CE >> i, 0, 0);
    send_bit(0, 0, 0);
    chk("par_ok_count", 32'(fifo_count), 1);
    chk("par_ok_perr", 32'(parity_err), 0);
    for (int i = 9; i >= 0; i--) send_bit(10'h2CE >> i, 0, 0);
    send_bit(1, 0, 0);
    chk("par_bad_perr", 32'(parity_err), 1);
    chk("par_bad_count", 32'(fifo_count), 1);
    @(negedge clk);
    chk("par_pulse_end", 32'(parity_err), 0);
    pop_one();
`endif
    send_frame(10'h2CE, 0);
    repeat (7) send_bit(1, 0, 0);
    data_bit = 1; confirm_bit = 1;
    #2 reset = 0;
    #1;
    chk("arst_rdy", 32'(data_ready), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(negedge clk);
    confirm_bit = 0; reset = 1;
    @(negedge clk);
    send_frame(10'h0F0, 0);
    chk("post_rst_instr", 32'(instr), 32'h0F0);
    chk("post_rst_count", 32'(fifo_count), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
